// File: rtl/clk_div_pkg.sv
// Shared types and ratio helpers for the clock-divider bank.
// Helpers work on 32-bit values so they serve any channel counter width.
package clk_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  // Ratios below 2 cannot produce a square wave; they divide by 2 instead.
  function automatic int unsigned clamp_ratio(input int unsigned ratio);
    return (ratio < 32'd2) ? 32'd2 : ratio;
  endfunction

  // Number of high cycles in a period: ceil(act/2).
  function automatic int unsigned hi_cycles(input int unsigned act);
    return (act + 32'd1) / 32'd2;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: IDLE/RUN FSM, period counter, shadow ratio and pending flag.
// clk_o and stb_o are registered, so they are glitch-free and reset asynchronously.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CW      = 8,
  parameter int DIV_RST = 4
) (
  input  logic          CLKIN,
  input  logic          rst_n,
  input  logic [CW-1:0] div_i,
  input  logic          load_i,
  input  logic          ch_en,
  output logic          clk_o,
  output logic          stb_o,
  output logic          settled
);

  localparam logic [CW-1:0] RST_RATIO = CW'(DIV_RST);

  ch_state_e     state_q, state_d;
  logic [CW-1:0] act_q, act_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          clk_d, stb_d;
  logic          restart;
  logic [CW-1:0] act_last;
  logic [CW-1:0] hi_last;
  logic [CW-1:0] div_clamped;

  assign act_last    = act_q - CW'(1);
  assign hi_last     = CW'(hi_cycles(32'(act_q)) - 32'd1);
  assign div_clamped = CW'(clamp_ratio(32'(div_i)));

  // NOTE: every always_comb output gets a default first, so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    clk_d   = clk_o;
    stb_d   = 1'b0;
    restart = 1'b0;

    case (state_q)
      IDLE: begin
        clk_d = 1'b0;
        cnt_d = '0;
        if (ch_en) begin
          state_d = RUN;
          restart = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == act_last) begin
          // ch_en only matters here, so a started period always completes.
          if (ch_en) begin
            restart = 1'b1;
          end else begin
            state_d = IDLE;
            clk_d   = 1'b0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == hi_last) clk_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A restart reads the shadow as it was before any load in this same cycle.
    if (restart) begin
      act_d = shadow_q;
      cnt_d = '0;
      clk_d = 1'b1;
      stb_d = 1'b1;
    end

    shadow_d  = load_i ? div_clamped : shadow_q;
    pending_d = load_i ? 1'b1 : (restart ? 1'b0 : pending_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLKIN or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      act_q     <= RST_RATIO;
      cnt_q     <= '0;
      shadow_q  <= RST_RATIO;
      pending_q <= 1'b0;
      clk_o     <= 1'b0;
      stb_o     <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_o     <= clk_d;
      stb_o     <= stb_d;
    end
  end

  assign settled = (state_q == RUN) && !pending_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent clock dividers sharing one load strobe, plus a
// registered flag saying every enabled channel runs at its latest ratio.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int CW      = 8,
  parameter int DIV_RST = 4
) (
  input  logic              CLKIN,
  input  logic              rst_n,
  input  logic [NCH*CW-1:0] div_i,
  input  logic              load_i,
  input  logic [NCH-1:0]    ch_en,
  output logic [NCH-1:0]    clk_o,
  output logic [NCH-1:0]    stb_o,
  output logic              clks_valid
);

  logic [NCH-1:0] settled;
  logic           valid_d;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_ch #(
      .CW      (CW),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .CLKIN   (CLKIN),
      .rst_n   (rst_n),
      .div_i   (div_i[i*CW +: CW]),
      .load_i  (load_i),
      .ch_en   (ch_en[i]),
      .clk_o   (clk_o[i]),
      .stb_o   (stb_o[i]),
      .settled (settled[i])
    );
  end

  // A load makes every channel pending, so the flag drops on the edge that sees it.
  assign valid_d = (|ch_en) && !load_i && (&(settled | ~ch_en));

  always_ff @(posedge CLKIN or negedge rst_n) begin
    if (!rst_n) clks_valid <= 1'b0;
    else        clks_valid <= valid_d;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed scenarios plus random traffic,
// compared every cycle against a period-position reference model.
module tb_clk_div_bank;

  localparam int NCH     = 3;
  localparam int CW      = 8;
  localparam int DIV_RST = 4;

  logic              CLKIN = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH*CW-1:0] div_i = '0;
  logic              load_i = 1'b0;
  logic [NCH-1:0]    ch_en = '0;
  logic [NCH-1:0]    clk_o;
  logic [NCH-1:0]    stb_o;
  logic              clks_valid;

  clk_div_bank #(
    .NCH     (NCH),
    .CW      (CW),
    .DIV_RST (DIV_RST)
  ) dut (
    .CLKIN      (CLKIN),
    .rst_n      (rst_n),
    .div_i      (div_i),
    .load_i     (load_i),
    .ch_en      (ch_en),
    .clk_o      (clk_o),
    .stb_o      (stb_o),
    .clks_valid (clks_valid)
  );

  always #5 CLKIN = ~CLKIN;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each channel is a position within a period of length act.
  bit m_run[NCH];
  int m_act[NCH];
  int m_pos[NCH];
  int m_shadow[NCH];
  bit m_pend[NCH];
  bit m_valid;

  function automatic int clamp2(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic bit exp_clk(input int i);
    return m_run[i] && (m_pos[i] < (m_act[i] + 1) / 2);
  endfunction

  function automatic bit exp_stb(input int i);
    return m_run[i] && (m_pos[i] == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_run[i]    = 1'b0;
      m_act[i]    = DIV_RST;
      m_pos[i]    = 0;
      m_shadow[i] = DIV_RST;
      m_pend[i]   = 1'b0;
    end
    m_valid = 1'b0;
  endtask

  // Advances the model by one CLKIN edge using the inputs currently driven.
  task automatic model_step();
    bit all_ok;
    bit restart;
    all_ok = 1'b1;
    for (int i = 0; i < NCH; i++)
      if (ch_en[i] && !(m_run[i] && !m_pend[i])) all_ok = 1'b0;
    m_valid = (ch_en != '0) && !load_i && all_ok;
    for (int i = 0; i < NCH; i++) begin
      restart = 1'b0;
      if (!m_run[i]) begin
        if (ch_en[i]) begin
          m_run[i] = 1'b1;
          m_pos[i] = 0;
          restart  = 1'b1;
        end
      end else if (m_pos[i] == m_act[i] - 1) begin
        m_pos[i] = 0;
        if (ch_en[i]) restart = 1'b1;
        else          m_run[i] = 1'b0;
      end else begin
        m_pos[i]++;
      end
      if (restart) m_act[i] = m_shadow[i];
      if (load_i) begin
        m_shadow[i] = clamp2(int'(div_i[i*CW +: CW]));
        m_pend[i]   = 1'b1;
      end else if (restart) begin
        m_pend[i] = 1'b0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [NCH-1:0] ec;
    logic [NCH-1:0] es;
    for (int i = 0; i < NCH; i++) begin
      ec[i] = exp_clk(i);
      es[i] = exp_stb(i);
    end
    check({tag, "_clk"}, 32'(clk_o), 32'(ec));
    check({tag, "_stb"}, 32'(stb_o), 32'(es));
    check({tag, "_valid"}, 32'(clks_valid), 32'(m_valid));
  endtask

  // Compare outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic cycle(input string tag, input logic [NCH*CW-1:0] d,
                       input logic ld, input logic [NCH-1:0] en);
    @(negedge CLKIN);
    compare_all(tag);
    div_i  = d;
    load_i = ld;
    ch_en  = en;
    model_step();
  endtask

  logic [15:0] pat_clk, pat_stb, pat_val, pat_c1;

  initial begin
    model_reset();

    // Reset state
    repeat (2) begin
      @(negedge CLKIN);
      compare_all("reset");
    end
    rst_n = 1'b1;
    model_step();

    // Nothing moves while no channel is enabled
    repeat (3) cycle("idle_after_reset", '0, 1'b0, '0);

    // Enable ch0 at the reset ratio 4
    cycle("en_ch0", '0, 1'b0, 3'b001);
    pat_clk = '0; pat_stb = '0; pat_val = '0;
    for (int k = 0; k < 8; k++) begin
      cycle("div4", '0, 1'b0, 3'b001);
      pat_clk[7-k] = clk_o[0];
      pat_stb[7-k] = stb_o[0];
      pat_val[7-k] = clks_valid;
      check("div4_others_low", 32'(clk_o[2:1]), 32'd0);
    end
    check("div4_clk_pattern", 32'(pat_clk[7:0]), 32'hCC);
    check("div4_stb_pattern", 32'(pat_stb[7:0]), 32'h88);
    check("div4_valid_pattern", 32'(pat_val[7:0]), 32'h7F);

    // Drop ch_en at cnt=0: period completes 2 high / 2 low, then silence
    pat_clk = '0; pat_stb = '0;
    for (int k = 0; k < 8; k++) begin
      cycle("drop_en", '0, 1'b0, 3'b000);
      pat_clk[7-k] = clk_o[0];
      pat_stb[7-k] = stb_o[0];
    end
    check("drop_en_clk", 32'(pat_clk[7:0]), 32'hC0);
    check("drop_en_stb", 32'(pat_stb[7:0]), 32'h80);

    // Load ratio 5 while idle, then enable: 3 high / 2 low
    cycle("load5", {8'd0, 8'd0, 8'd5}, 1'b1, 3'b000);
    cycle("load5_en", '0, 1'b0, 3'b001);
    pat_clk = '0;
    for (int k = 0; k < 10; k++) begin
      cycle("div5", '0, 1'b0, 3'b001);
      pat_clk[9-k] = clk_o[0];
    end
    check("div5_clk_pattern", 32'(pat_clk[9:0]), 32'h39C);

    // Stop, load 4, re-enable, then load 6 at cnt=1
    repeat (8) cycle("stop", '0, 1'b0, 3'b000);
    cycle("load4", {8'd0, 8'd0, 8'd4}, 1'b1, 3'b000);
    cycle("load4_en", '0, 1'b0, 3'b001);
    pat_clk = '0; pat_val = '0;
    for (int k = 0; k < 16; k++) begin
      cycle("reload6", {8'd0, 8'd0, 8'd6}, (k == 1), 3'b001);
      pat_clk[15-k] = clk_o[0];
      pat_val[15-k] = clks_valid;
    end
    check("reload6_clk_pattern", 32'(pat_clk), 32'hCE38);
    check("reload6_valid_pattern", 32'(pat_val), 32'h47FF);

    // Ratios 0 and 1 both divide by 2
    repeat (10) cycle("stop2", '0, 1'b0, 3'b000);
    cycle("load01", {8'd0, 8'd1, 8'd0}, 1'b1, 3'b000);
    cycle("load01_en", '0, 1'b0, 3'b011);
    pat_clk = '0; pat_c1 = '0; pat_stb = '0;
    for (int k = 0; k < 6; k++) begin
      cycle("div2", '0, 1'b0, 3'b011);
      pat_clk[5-k] = clk_o[0];
      pat_c1[5-k]  = clk_o[1];
      pat_stb[5-k] = stb_o[1];
    end
    check("div2_ch0_clk", 32'(pat_clk[5:0]), 32'h2A);
    check("div2_ch1_clk", 32'(pat_c1[5:0]), 32'h2A);
    check("div2_ch1_stb", 32'(pat_stb[5:0]), 32'h2A);

    // Random traffic against the model
    for (int k = 0; k < 800; k++) begin
      logic [NCH*CW-1:0] d;
      logic [NCH-1:0]    en;
      for (int i = 0; i < NCH; i++) d[i*CW +: CW] = CW'($urandom_range(0, 9));
      en = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : ch_en;
      cycle("rand", d, ($urandom_range(0, 15) == 0), en);
    end

    // Asynchronous reset in the middle of a high phase
    repeat (20) cycle("quiesce", '0, 1'b0, 3'b000);
    cycle("all_en", '0, 1'b0, 3'b111);
    @(posedge CLKIN);
    #2;
    check("pre_reset_clk", 32'(clk_o), 32'h7);
    rst_n = 1'b0;
    #1;
    check("async_rst_clk", 32'(clk_o), 32'd0);
    check("async_rst_stb", 32'(stb_o), 32'd0);
    check("async_rst_valid", 32'(clks_valid), 32'd0);
    model_reset();
    @(negedge CLKIN);
    compare_all("in_reset");
    div_i  = '0;
    load_i = 1'b0;
    ch_en  = '0;
    rst_n  = 1'b1;
    model_step();
    repeat (3) cycle("post_reset_idle", '0, 1'b0, 3'b000);
    repeat (12) cycle("post_reset_run", '0, 1'b0, 3'b101);
    @(negedge CLKIN);
    compare_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
